// File: rtl/ryuki_datatypes_pkg.sv
// Shared trace datatypes: the trace_output record, frame geometry and a record flattener.
// TRACE_SER_CHECKSUM_EN appends an XOR checksum word to every serialised frame.
package ryuki_datatypes;

    typedef struct packed {
        int time_start;
        int time_end;
    } trace_span_t;

    typedef struct packed {
        int          time_start;
        int          time_end;
        trace_span_t mem_access_req;
        trace_span_t mem_access_data;
    } trace_if_t;

    typedef struct packed {
        int time_start;
        int time_end;
    } trace_id_t;

    typedef struct packed {
        int          time_start;
        int          time_end;
        trace_span_t mem_access_req;
    } trace_ex_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] addr;
        trace_if_t   if_data;
        trace_id_t   id_data;
        trace_ex_t   ex_data;
    } trace_output;

    localparam int TRACE_PAYLOAD_WORDS = 14;
`ifdef TRACE_SER_CHECKSUM_EN
    localparam int TRACE_FRAME_WORDS = 16;
`else
    localparam int TRACE_FRAME_WORDS = 15;
`endif
    localparam logic [7:0] TRACE_MAGIC = 8'hA5;

    typedef enum logic {
        IDLE,
        SEND
    } trace_ser_state_t;

    typedef logic [TRACE_PAYLOAD_WORDS-1:0][31:0] trace_payload_t;

    // Element k is frame word k+1; the header is built by the serialiser.
    function automatic trace_payload_t trace_flatten(input trace_output rec);
        trace_payload_t w;
        w[0]  = rec.instruction;
        w[1]  = rec.addr;
        w[2]  = rec.if_data.time_start;
        w[3]  = rec.if_data.time_end;
        w[4]  = rec.if_data.mem_access_req.time_start;
        w[5]  = rec.if_data.mem_access_req.time_end;
        w[6]  = rec.if_data.mem_access_data.time_start;
        w[7]  = rec.if_data.mem_access_data.time_end;
        w[8]  = rec.id_data.time_start;
        w[9]  = rec.id_data.time_end;
        w[10] = rec.ex_data.time_start;
        w[11] = rec.ex_data.time_end;
        w[12] = rec.ex_data.mem_access_req.time_start;
        w[13] = rec.ex_data.mem_access_req.time_end;
        return w;
    endfunction

endpackage

// File: rtl/trace_output_serialiser_fifo.sv
// trace_record_fifo: power-of-two synchronous FIFO of trace_output records.
// Push while full and pop while empty are ignored.
module trace_record_fifo
    import ryuki_datatypes::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  trace_output              wr_data,
    input  logic                     pop,
    output trace_output              rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    trace_output   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   level_reg, level_next;
    logic          push_ok, pop_ok;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];
    assign level   = level_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        level_next  = level_reg;
        if (push_ok)
            wr_ptr_next = wr_ptr_reg + 1'b1;
        if (pop_ok)
            rd_ptr_next = rd_ptr_reg + 1'b1;
        if (push_ok && !pop_ok)
            level_next = level_reg + 1'b1;
        else if (!push_ok && pop_ok)
            level_next = level_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/trace_output_serialiser.sv
// Buffers trace_output records and emits each as a fixed-length frame of 32-bit words.
// Build option: TRACE_SER_CHECKSUM_EN adds a trailing XOR checksum word.
module trace_output_serialiser
    import ryuki_datatypes::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] MAGIC      = TRACE_MAGIC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          trace_valid_i,
    output logic                          trace_ready_o,
    input  trace_output                   trace_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [31:0]                   out_data_o,
    output logic                          out_last_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [15:0]                   seq_o
);
    localparam logic [3:0] LAST_IDX = 4'(TRACE_FRAME_WORDS - 1);

    trace_ser_state_t state_reg, state_next;
    logic [3:0]       word_idx_reg, word_idx_next;
    logic [15:0]      seq_reg, seq_next;
    trace_output      shadow_reg, shadow_next;
    trace_output      fifo_head;
    logic             fifo_full, fifo_empty, fifo_pop;
    trace_payload_t   payload;
    logic [31:0]      header_word, frame_word;

    trace_record_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (trace_valid_i),
        .wr_data (trace_data_i),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_o)
    );

    always_comb begin
        state_next    = state_reg;
        word_idx_next = word_idx_reg;
        seq_next      = seq_reg;
        shadow_next   = shadow_reg;
        fifo_pop      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    shadow_next   = fifo_head;
                    word_idx_next = '0;
                    state_next    = SEND;
                end
            end
            SEND: begin
                if (out_ready_i) begin
                    if (word_idx_reg == LAST_IDX) begin
                        seq_next      = seq_reg + 16'd1;
                        word_idx_next = '0;
                        // Chain straight into the next record to avoid a bubble.
                        if (!fifo_empty) begin
                            fifo_pop    = 1'b1;
                            shadow_next = fifo_head;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        word_idx_next = word_idx_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            word_idx_reg <= '0;
            seq_reg      <= '0;
            shadow_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            word_idx_reg <= word_idx_next;
            seq_reg      <= seq_next;
            shadow_reg   <= shadow_next;
        end
    end

    assign payload     = trace_flatten(shadow_reg);
    assign header_word = {MAGIC, seq_reg, 8'(TRACE_FRAME_WORDS)};

`ifdef TRACE_SER_CHECKSUM_EN
    logic [31:0] checksum;
    always_comb begin
        checksum = header_word;
        for (int i = 0; i < TRACE_PAYLOAD_WORDS; i++)
            checksum = checksum ^ payload[i];
    end
`endif

    // Output is a pure function of registered state, so it holds while stalled.
    always_comb begin
        frame_word = '0;
        if (word_idx_reg == 4'd0)
            frame_word = header_word;
        else if (word_idx_reg <= 4'(TRACE_PAYLOAD_WORDS))
            frame_word = payload[word_idx_reg - 4'd1];
`ifdef TRACE_SER_CHECKSUM_EN
        else
            frame_word = checksum;
`endif
    end

    assign trace_ready_o = !fifo_full;
    assign out_valid_o   = (state_reg == SEND);
    assign out_data_o    = out_valid_o ? frame_word : 32'd0;
    assign out_last_o    = out_valid_o && (word_idx_reg == LAST_IDX);
    assign seq_o         = seq_reg;

endmodule

// File: tb/tb_trace_output_serialiser.sv
// Scoreboard bench for trace_output_serialiser: expected frame words are queued at push time
// and compared as the sink accepts them.
module tb_trace_output_serialiser;
    import ryuki_datatypes::*;

`ifdef TRACE_SER_CHECKSUM_EN
    localparam int          FL      = 16;
    localparam logic [31:0] HDR_SEQ0 = 32'hA5000010;
`else
    localparam int          FL      = 15;
    localparam logic [31:0] HDR_SEQ0 = 32'hA500000F;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_valid_i = 1'b0;
    logic        trace_ready_o;
    trace_output trace_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic [2:0]  fifo_level_o;
    logic [15:0] seq_o;

    trace_output_serialiser #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trace_valid_i (trace_valid_i),
        .trace_ready_o (trace_ready_o),
        .trace_data_i  (trace_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_last_o    (out_last_o),
        .fifo_level_o  (fifo_level_o),
        .seq_o         (seq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [15:0] seq;
        int          idx;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_seq = 16'd0;
    bit          mon_en = 1'b0;
    bit          rand_ready = 1'b0;
    int          gap_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push_record(input trace_output r);
        logic [31:0] w [FL];
        w[0]  = {8'hA5, exp_seq, 8'(FL)};
        w[1]  = r.instruction;
        w[2]  = r.addr;
        w[3]  = r.if_data.time_start;
        w[4]  = r.if_data.time_end;
        w[5]  = r.if_data.mem_access_req.time_start;
        w[6]  = r.if_data.mem_access_req.time_end;
        w[7]  = r.if_data.mem_access_data.time_start;
        w[8]  = r.if_data.mem_access_data.time_end;
        w[9]  = r.id_data.time_start;
        w[10] = r.id_data.time_end;
        w[11] = r.ex_data.time_start;
        w[12] = r.ex_data.time_end;
        w[13] = r.ex_data.mem_access_req.time_start;
        w[14] = r.ex_data.mem_access_req.time_end;
`ifdef TRACE_SER_CHECKSUM_EN
        w[15] = 32'd0;
        for (int i = 0; i < 15; i++)
            w[15] = w[15] ^ w[i];
`endif
        for (int i = 0; i < FL; i++)
            sb_q.push_back('{data: w[i], last: (i == FL - 1), seq: exp_seq, idx: i});
        $display("push rec seq=%04h instr=%08h addr=%08h", exp_seq, r.instruction, r.addr);
        exp_seq = exp_seq + 16'd1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_rec(input trace_output r);
        bit ok = 1'b0;
        trace_valid_i = 1'b1;
        trace_data_i  = r;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (trace_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok)
            sb_push_record(r);
        else
            check("push_timeout", 32'(trace_ready_o), 32'd1);
        @(posedge clk);
        #1;
        trace_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic trace_output rand_rec();
        trace_output r;
        r.instruction                        = $urandom();
        r.addr                               = $urandom();
        r.if_data.time_start                 = $urandom();
        r.if_data.time_end                   = $urandom();
        r.if_data.mem_access_req.time_start  = $urandom();
        r.if_data.mem_access_req.time_end    = $urandom();
        r.if_data.mem_access_data.time_start = $urandom();
        r.if_data.mem_access_data.time_end   = $urandom();
        r.id_data.time_start                 = $urandom();
        r.id_data.time_end                   = $urandom();
        r.ex_data.time_start                 = $urandom();
        r.ex_data.time_end                   = $urandom();
        r.ex_data.mem_access_req.time_start  = $urandom();
        r.ex_data.mem_access_req.time_end    = $urandom();
        return r;
    endfunction

    // Output monitor: scoreboard compare on each accepted word, hold check on stalls.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid_o), 32'd1);
                check("hold_data", out_data_o, prev_data);
                check("hold_last", 32'(out_last_o), 32'(prev_last));
            end
            if (out_valid_o && out_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("word", out_data_o, e.data);
                    check("last", 32'(out_last_o), 32'(e.last));
                    check("seq", 32'(seq_o), 32'(e.seq));
                    if (e.last)
                        $display("frame done seq=%04h last_word=%08h", e.seq, out_data_o);
                end
            end
            if (!out_valid_o && out_ready_i && sb_q.size() > 0)
                gap_cnt++;
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            prev_last  = out_last_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready_i = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        trace_output r;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(trace_ready_o), 32'd1);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_data", out_data_o, 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        check("rst_level", 32'(fifo_level_o), 32'd0);
        check("rst_seq", 32'(seq_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Single record, latency to header, full frame
        out_ready_i = 1'b1;
        r.instruction                        = 32'h00A00093;
        r.addr                               = 32'h80;
        r.if_data.time_start                 = 1;
        r.if_data.time_end                   = 2;
        r.if_data.mem_access_req.time_start  = 3;
        r.if_data.mem_access_req.time_end    = 4;
        r.if_data.mem_access_data.time_start = 5;
        r.if_data.mem_access_data.time_end   = 6;
        r.id_data.time_start                 = 7;
        r.id_data.time_end                   = 8;
        r.ex_data.time_start                 = 9;
        r.ex_data.time_end                   = 10;
        r.ex_data.mem_access_req.time_start  = 11;
        r.ex_data.mem_access_req.time_end    = 12;
        push_rec(r);
        @(negedge clk);
        check("lat_n1_valid", 32'(out_valid_o), 32'd0);
        @(negedge clk);
        check("lat_n2_valid", 32'(out_valid_o), 32'd1);
        check("lat_n2_header", out_data_o, HDR_SEQ0);
        @(posedge clk);
        #1;
        wait_drain();
        check("t1_idle_valid", 32'(out_valid_o), 32'd0);

        // Fill FIFO while sink stalls, then release for back-to-back frames
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++)
            push_rec(rand_rec());
        @(negedge clk);
        check("full_level", 32'(fifo_level_o), 32'd4);
        check("full_ready", 32'(trace_ready_o), 32'd0);
        @(posedge clk);
        #1;
        gap_cnt     = 0;
        out_ready_i = 1'b1;
        wait_drain();
        check("b2b_gaps", 32'(gap_cnt), 32'd0);

        // Random sink stalls over 20 records
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            push_rec(rand_rec());
        wait_drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready_i = 1'b1;

        // Sequence wrap 0xFFFF -> 0x0000
        force dut.seq_reg = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.seq_reg;
        exp_seq = 16'hFFFF;
        push_rec(rand_rec());
        push_rec(rand_rec());
        wait_drain();
        check("seq_after_wrap", 32'(seq_o), 32'h0001);

        // Asynchronous reset while word 7 of a frame is on the bus
        push_rec(rand_rec());
        push_rec(rand_rec());
        repeat (7) @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_mid_valid", 32'(out_valid_o), 32'd0);
        check("rst_mid_last", 32'(out_last_o), 32'd0);
        check("rst_mid_level", 32'(fifo_level_o), 32'd0);
        check("rst_mid_ready", 32'(trace_ready_o), 32'd1);
        check("rst_mid_seq", 32'(seq_o), 32'd0);
        check("rst_mid_words_left", 32'(sb_q.size()), 32'(2 * FL - 7));
        sb_q.delete();
        exp_seq = 16'd0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        push_rec(rand_rec());
        @(negedge clk);
        @(negedge clk);
        check("post_rst_header", out_data_o, HDR_SEQ0);
        @(posedge clk);
        #1;
        wait_drain();
        check("end_level", 32'(fifo_level_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
